joypad_scanner: RTL and testbench
=================================

Name: joypad_scanner

Overview:
Front end for the FF00 joypad register: it conditions eight raw physical buttons and presents them to the register.
- Synchronizes and debounces each button.
- Multiplexes the debounced state onto the 4-bit active-low button_data bus using the register's button_sel lines.
- Generates the joypad interrupt request on any high-to-low transition of button_data, with an int_ack handshake.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable synchronized samples required before a button changes state; legal range 1..65535.
- SYNC_STAGES, 2: synchronizer flop depth per raw input; minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_raw  in  8  asynchronous raw buttons, 1 = pressed. Bit map: 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.
- button_sel  in  2  from the joypad register. bit0 = 0 selects directions; bit1 = 0 selects action buttons.
- button_data  out  4  active-low line state to the joypad register
- btn_state  out  8  debounced buttons, 1 = pressed, same bit map as btn_raw
- int_req  out  1  joypad interrupt request, level, held until acknowledged
- int_ack  in  1  single-cycle interrupt acknowledge

Behaviour:
Reset:
- Reset is synchronous, active-high; clock is clock.
- On reset: all synchronizer flops 0, btn_state 8'h00, all debounce counters 0, int_req 0, prev_data 4'hF.
- Reset asserted mid-debounce discards the partial count.

Synchronizer:
- SYNC_STAGES-deep chain per bit.
- sync[i] is the final stage of that chain.

Debounce (independent per bit i, 16-bit counter cnt[i]):
- If sync[i] == btn_state[i]: cnt[i] <= 0.
- Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_state[i] <= sync[i] and cnt[i] <= 0.
- Else: cnt[i] <= cnt[i]+1.
- Any sample agreeing with btn_state restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency from a clean raw edge to btn_state change is exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
- The counter never exceeds DEBOUNCE_CYCLES-1 and does not wrap.

button_data (combinational from btn_state and button_sel; no clock latency):
- dir = btn_state[3:0]; act = btn_state[7:4].
- button_data = ~(((~button_sel[0]) ? dir : 4'h0) | ((~button_sel[1]) ? act : 4'h0)).
- sel = 2'b11 gives 4'hF.
- sel = 2'b00 ORs both groups.

Interrupt:
- prev_data <= button_data every cycle.
- fall = prev_data & ~button_data, checked per bit.
- Falls caused by a button_sel change also count; this is intended and matches DMG behaviour.
- If |fall is true: int_req <= 1.
- Else if int_ack: int_req <= 0.
- If a new fall and int_ack occur in the same cycle, set wins and int_req stays 1.
- int_ack while int_req = 0 has no effect.
- Rising edges never set int_req.

Optional Feature:
JOYPAD_SOCD_EN (opposing-direction cleaning):
- When defined, the direction group is filtered before muxing:
  - if btn_state[0] and btn_state[1] (Right+Left) are both pressed, both are reported released;
  - if btn_state[2] and btn_state[3] (Up+Down) are both pressed, both are reported released.
- btn_state itself stays unfiltered.
- The interrupt edge detector sees the filtered button_data.
- When undefined, dir = btn_state[3:0] unmodified.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless noted):
1. Reset, then sel=2'b10, hold btn_raw=8'h01 -> btn_state[0] rises exactly 6 edges after the raw edge; button_data 4'hF then 4'hE; int_req=1 on the next edge; int_ack pulse -> int_req=0.
2. Pulse btn_raw[4] high for 3 cycles -> btn_state remains 8'h00, button_data 4'hF under every sel, int_req stays 0.
3. Stable btn_state=8'h90 (A+Start): sel=2'b01 gives 4'h6; sel=2'b10 gives 4'hF; sel=2'b00 gives 4'h6; sel=2'b11 gives 4'hF. Switching sel 2'b11->2'b01 raises int_req.
4. With int_req=1 pending, press another selected button so its fall coincides with int_ack -> int_req remains 1; a second int_ack alone clears it.
5. Assert reset 2 cycles into a debounce of btn_raw[2] -> all outputs return to reset values; after release, the full 6-edge latency is required again.
6. JOYPAD_SOCD_EN defined, btn_raw=8'h03 stable, sel=2'b10 -> btn_state=8'h03, button_data=4'hF, no int_req. Without the macro -> button_data=4'hC and int_req=1.

Source files
------------

// File: rtl/joypad_scanner_if.sv
// rtl/joypad_scanner_if.sv - joypad register side bus: line select, line data, interrupt handshake
interface joypad_scanner_if;
    logic [1:0] button_sel;
    logic [3:0] button_data;
    logic       int_req;
    logic       int_ack;

    // Register side: drives the select lines and acknowledges the interrupt
    modport master (
        output button_sel,
        output int_ack,
        input  button_data,
        input  int_req
    );

    // Scanner side: presents active-low line state and raises the interrupt
    modport slave (
        input  button_sel,
        input  int_ack,
        output button_data,
        output int_req
    );
endinterface

// File: rtl/joypad_scanner.sv
// rtl/joypad_scanner.sv - joypad front end: sync, debounce, FF00 line mux, interrupt; optional JOYPAD_SOCD_EN
module joypad_scanner #(
    parameter int DEBOUNCE_CYCLES = 20000,  // legal 1..65535
    parameter int SYNC_STAGES     = 2       // at least 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       btn_raw,
    output logic [7:0]       btn_state,
    joypad_scanner_if.slave  jp
);

    // Last count value before a disagreeing button is accepted
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Synchronizer chains: bit [0] samples the raw pin, bit [SYNC_STAGES-1] feeds the debouncer
    logic [7:0][SYNC_STAGES-1:0] sync_chain_q;
    logic [7:0]                  sync_w;

    // Debounce state
    logic [7:0][15:0] cnt_q;
    logic [7:0][15:0] cnt_d;
    logic [7:0]       state_q;
    logic [7:0]       state_d;

    // Line mux and interrupt
    logic [3:0] dir_w;
    logic [3:0] act_w;
    logic [3:0] button_data_w;
    logic [3:0] prev_data_q;
    logic [3:0] fall_w;
    logic       int_req_q;
    logic       int_req_d;

    // Shift each raw button through its own synchronizer chain
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (reset) begin
                sync_chain_q[i] <= '0;
            end else begin
                sync_chain_q[i] <= {sync_chain_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            end
        end
    end

    // Pick the final synchronizer stage of every chain
    always_comb begin
        sync_w = '0;
        for (int i = 0; i < 8; i++) begin
            sync_w[i] = sync_chain_q[i][SYNC_STAGES-1];
        end
    end

    // Per-button debounce: count consecutive disagreeing samples, accept on the last one
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        for (int i = 0; i < 8; i++) begin
            if (sync_w[i] == state_q[i]) begin
                // Any agreeing sample restarts the count, which rejects short glitches
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = sync_w[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Debounce registers; a reset mid-count throws the partial count away
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign btn_state = state_q;

    // Direction group, optionally cleaned of opposing presses before it reaches the bus
    always_comb begin
        dir_w = state_q[3:0];
`ifdef JOYPAD_SOCD_EN
        // Right+Left or Up+Down held together report as neither; btn_state keeps the raw truth
        if (state_q[0] && state_q[1]) begin
            dir_w[1:0] = 2'b00;
        end
        if (state_q[2] && state_q[3]) begin
            dir_w[3:2] = 2'b00;
        end
`endif
    end

    assign act_w = state_q[7:4];

    // Active-low line mux: a low select bit enables its group, both groups OR when both are low
    always_comb begin
        button_data_w = ~((jp.button_sel[0] ? 4'h0 : dir_w) |
                          (jp.button_sel[1] ? 4'h0 : act_w));
    end

    assign jp.button_data = button_data_w;

    // High-to-low on any line raises the request; select changes count too, as on the DMG
    always_comb begin
        fall_w    = prev_data_q & ~button_data_w;
        int_req_d = int_req_q;
        if (|fall_w) begin
            // A fresh fall beats a simultaneous acknowledge
            int_req_d = 1'b1;
        end else if (jp.int_ack) begin
            int_req_d = 1'b0;
        end
    end

    // Edge detector history and interrupt request level
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_data_q <= 4'hF;
            int_req_q   <= 1'b0;
        end else begin
            prev_data_q <= button_data_w;
            int_req_q   <= int_req_d;
        end
    end

    assign jp.int_req = int_req_q;

endmodule

// File: tb/tb_joypad_scanner.sv
// tb/tb_joypad_scanner.sv - randomized scoreboard bench for joypad_scanner against a window-based model
module tb_joypad_scanner;

    localparam int D    = 4;
    localparam int S    = 2;
    localparam int HLEN = D + S;

    typedef struct {
        logic [7:0] st;
        logic [3:0] bd;
        logic       req;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] btn_raw = 8'h00;
    logic [7:0] btn_state;

    joypad_scanner_if jp ();

    joypad_scanner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_state (btn_state),
        .jp        (jp)
    );

    always #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    // Reference model state
    logic [7:0] hist [HLEN];
    logic [7:0] m_state = 8'h00;
    logic [3:0] m_prev  = 4'hF;
    logic       m_req   = 1'b0;

    // Line value the FF00 register would read for a given debounced state and select
    function automatic logic [3:0] line_model(input logic [7:0] st, input logic [1:0] sel);
        logic [3:0] dir;
        logic [3:0] act;
        logic [3:0] pressed;
        dir = st[3:0];
        act = st[7:4];
`ifdef JOYPAD_SOCD_EN
        if (dir[0] && dir[1]) dir[1:0] = 2'b00;
        if (dir[2] && dir[3]) dir[3:2] = 2'b00;
`endif
        pressed = 4'h0;
        if (sel[0] == 1'b0) pressed = pressed | dir;
        if (sel[1] == 1'b0) pressed = pressed | act;
        return ~pressed;
    endfunction

    // Advance the model across one rising edge using the inputs present at that edge.
    // A button flips once the last D samples seen by the debouncer (raw delayed by S edges)
    // all disagree with its current state.
    task automatic model_step();
        logic [3:0] bd;
        logic       all_diff;
        if (reset) begin
            for (int j = 0; j < HLEN; j++) hist[j] = 8'h00;
            m_state = 8'h00;
            m_prev  = 4'hF;
            m_req   = 1'b0;
        end else begin
            bd = line_model(m_state, jp.button_sel);
            if ((m_prev & ~bd) != 4'h0) m_req = 1'b1;
            else if (jp.int_ack)        m_req = 1'b0;
            m_prev = bd;
            for (int j = 0; j < HLEN - 1; j++) hist[j] = hist[j+1];
            hist[HLEN-1] = btn_raw;
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist[j][i] == m_state[i]) all_diff = 1'b0;
                end
                if (all_diff) m_state[i] = ~m_state[i];
            end
        end
    endtask

    // One clock of stimulus: step the model at the edge, apply new inputs, queue the expectation
    task automatic drive(input logic [7:0] raw, input logic [1:0] sel, input logic ack, input logic rst);
        exp_t e;
        @(posedge clock);
        model_step();
        #2;
        btn_raw       = raw;
        jp.button_sel = sel;
        jp.int_ack    = ack;
        reset         = rst;
        e.st  = m_state;
        e.bd  = line_model(m_state, sel);
        e.req = m_req;
        sb.push_back(e);
    endtask

    task automatic hold(input logic [7:0] raw, input logic [1:0] sel, input int n);
        for (int k = 0; k < n; k++) drive(raw, sel, 1'b0, 1'b0);
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (btn_state !== e.st) begin
                    failures++;
                    $display("FAIL btn_state t=%0t got=%h exp=%h", $time, btn_state, e.st);
                end
                checks++;
                if (jp.button_data !== e.bd) begin
                    failures++;
                    $display("FAIL button_data t=%0t sel=%b got=%h exp=%h", $time, jp.button_sel, jp.button_data, e.bd);
                end
                checks++;
                if (jp.int_req !== e.req) begin
                    failures++;
                    $display("FAIL int_req t=%0t got=%b exp=%b", $time, jp.int_req, e.req);
                end
            end
        end
    end

    initial begin
        logic [7:0] raw;
        logic [1:0] sel;
        jp.button_sel = 2'b11;
        jp.int_ack    = 1'b0;
        for (int j = 0; j < HLEN; j++) hist[j] = 8'h00;

        // Reset state
        for (int k = 0; k < 3; k++) drive(8'h00, 2'b11, 1'b0, 1'b1);
        hold(8'h00, 2'b10, 2);

        // Right press: full latency, line falls, interrupt raised, then acknowledged
        hold(8'h01, 2'b10, 9);
        drive(8'h01, 2'b10, 1'b1, 1'b0);
        hold(8'h01, 2'b10, 3);

        // Short A glitch is rejected under every select
        hold(8'h11, 2'b10, 3);
        hold(8'h01, 2'b01, 3);
        hold(8'h01, 2'b00, 3);
        hold(8'h01, 2'b11, 3);
        hold(8'h01, 2'b10, 3);

        // A+Start held, select sweep, then 11 -> 01 raises the interrupt
        hold(8'h90, 2'b11, 10);
        drive(8'h90, 2'b11, 1'b1, 1'b0);
        hold(8'h90, 2'b01, 2);
        hold(8'h90, 2'b10, 2);
        hold(8'h90, 2'b00, 2);
        hold(8'h90, 2'b11, 2);
        hold(8'h90, 2'b01, 3);

        // B press lands its fall on the same edge as an acknowledge, then a lone acknowledge clears
        hold(8'hB0, 2'b01, 6);
        drive(8'hB0, 2'b01, 1'b1, 1'b0);
        hold(8'hB0, 2'b01, 2);
        drive(8'hB0, 2'b01, 1'b1, 1'b0);
        hold(8'hB0, 2'b01, 2);

        // Release everything, then reset two cycles into an Up debounce
        hold(8'h00, 2'b11, 10);
        hold(8'h04, 2'b10, 2);
        drive(8'h04, 2'b10, 1'b0, 1'b1);
        hold(8'h04, 2'b10, 9);

        // Right+Left held together
        hold(8'h00, 2'b10, 8);
        hold(8'h03, 2'b10, 10);
        drive(8'h03, 2'b10, 1'b1, 1'b0);
        hold(8'h0F, 2'b10, 10);

        // Randomized traffic: slowly toggling buttons so both glitches and real presses occur
        raw = 8'h00;
        sel = 2'b11;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
            end
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            drive(raw, sel, ($urandom_range(0, 4) == 0), ($urandom_range(0, 399) == 0));
        end

        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
